// File: rtl/sisc_mem_arb_if.sv
// sisc_mem_arb_if
// Bundles the fetch (if_*), data (dm_*) and memory (mem_*) signals of the
// SISC memory arbiter, plus its busy flag.
//   slave  : arbiter view (takes requests and read data, drives grants,
//            responses and the memory strobes)
//   master : environment view (requesters plus memory model)
// Parameters: AW address width, DW data width.
interface sisc_mem_arb_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_valid;
    logic [DW-1:0] if_rdata;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_valid;
    logic [DW-1:0] dm_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/sisc_mem_arb.sv
// sisc_mem_arb
// Shares the single-port SISC memory between the instruction-fetch port (IF)
// and the load/store data port (DM). One access is outstanding at a time:
// IDLE -> ACCESS (1 cycle, grant + mem_en) -> WAIT (LAT cycles, reads only)
// -> RESP (1 cycle valid pulse) -> IDLE. Every output is a register.
// Ports:
//   clk   : system clock, rising edge
//   rst_f : asynchronous active-low reset
//   bus   : sisc_mem_arb_if.slave (requests, grants, responses, memory side)
// Parameters: AW address width, DW data width, LAT read latency (1..7).
// Optional feature: define SISC_MEM_ARB_RR_EN for round-robin selection;
// without it DM has fixed priority over IF.
module sisc_mem_arb #(
    parameter int AW  = 16,
    parameter int DW  = 32,
    parameter int LAT = 2
) (
    input  logic              clk,
    input  logic              rst_f,
    sisc_mem_arb_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [2:0] LAT_C = 3'(LAT);

    state_t        state_q;
    logic [2:0]    cnt_q;
    logic          win_dm_q;      // 1 = DM owns the access in flight
    logic          if_gnt_q;
    logic          if_valid_q;
    logic [DW-1:0] if_rdata_q;
    logic          dm_gnt_q;
    logic          dm_valid_q;
    logic [DW-1:0] dm_rdata_q;
    logic          mem_en_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          busy_q;

    logic          any_req_s;
    logic          sel_dm_s;

`ifdef SISC_MEM_ARB_RR_EN
    logic          rr_last_dm_q;  // 0 = IF won last, 1 = DM won last

    // Round-robin winner: on contention the port that did not win last time
    always_comb begin
        sel_dm_s = 1'b0;
        if (bus.dm_req && bus.if_req) begin
            sel_dm_s = ~rr_last_dm_q;
        end else if (bus.dm_req) begin
            sel_dm_s = 1'b1;
        end else begin
            sel_dm_s = 1'b0;
        end
    end
`else
    // Fixed-priority winner: the pending data access belongs to the
    // instruction already in flight, so DM beats IF
    always_comb begin
        sel_dm_s = 1'b0;
        if (bus.dm_req) begin
            sel_dm_s = 1'b1;
        end else begin
            sel_dm_s = 1'b0;
        end
    end
`endif

    assign any_req_s = bus.if_req | bus.dm_req;

    // Arbitration FSM with registered grants, responses and memory strobes
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            win_dm_q     <= 1'b0;
            if_gnt_q     <= 1'b0;
            if_valid_q   <= 1'b0;
            if_rdata_q   <= {DW{1'b0}};
            dm_gnt_q     <= 1'b0;
            dm_valid_q   <= 1'b0;
            dm_rdata_q   <= {DW{1'b0}};
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {AW{1'b0}};
            mem_wdata_q  <= {DW{1'b0}};
            busy_q       <= 1'b0;
`ifdef SISC_MEM_ARB_RR_EN
            rr_last_dm_q <= 1'b0;
`endif
        end else begin
            // grants and valids are single-cycle pulses unless set below
            if_gnt_q   <= 1'b0;
            dm_gnt_q   <= 1'b0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (any_req_s) begin
                        state_q     <= ST_ACCESS;
                        win_dm_q    <= sel_dm_s;
                        if_gnt_q    <= ~sel_dm_s;
                        dm_gnt_q    <= sel_dm_s;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= sel_dm_s & bus.dm_we;
                        mem_addr_q  <= sel_dm_s ? bus.dm_addr : bus.if_addr;
                        mem_wdata_q <= sel_dm_s ? bus.dm_wdata : {DW{1'b0}};
                        busy_q      <= 1'b1;
`ifdef SISC_MEM_ARB_RR_EN
                        rr_last_dm_q <= sel_dm_s;
`endif
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    // a store completes on the access cycle itself
                    if (win_dm_q && mem_we_q) begin
                        state_q    <= ST_RESP;
                        dm_valid_q <= 1'b1;
                    end else begin
                        state_q <= ST_WAIT;
                        cnt_q   <= LAT_C;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 3'd1) begin
                        cnt_q   <= 3'd0;
                        state_q <= ST_RESP;
                        if (win_dm_q) begin
                            dm_rdata_q <= bus.mem_rdata;
                            dm_valid_q <= 1'b1;
                        end else begin
                            if_rdata_q <= bus.mem_rdata;
                            if_valid_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    cnt_q    <= 3'd0;
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_gnt    = dm_gnt_q;
    assign bus.dm_valid  = dm_valid_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sisc_mem_arb.sv
// tb_sisc_mem_arb
// Directed bench for sisc_mem_arb: a LAT=2 instance with a small memory model
// for the functional cases, plus LAT=1 and LAT=7 instances for latency and
// grant-spacing sweeps. Builds with or without SISC_MEM_ARB_RR_EN.
module tb_sisc_mem_arb;

    logic clk;
    logic rst_f;
    logic sw_req;
    int   cyc;
    int   n_cmp;
    int   n_err;
    int   overlap_cnt;
    int   ifv_cnt;

    int   ngr;
    int   gord [4];
    int   gcyc [4];
    int   t_last;
    int   t_if;
    int   saw_if;
    int   v0;

    logic [31:0] mem [0:255];

    sisc_mem_arb_if #(.AW(16), .DW(32)) bus ();

    sisc_mem_arb #(.AW(16), .DW(32), .LAT(2)) u_dut (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (bus.slave)
    );

    // Memory model: location 0x0010 is preloaded, the rest is written by stores
    assign bus.mem_rdata = (bus.mem_addr == 16'h0010) ? 32'hDEADBEEF : mem[bus.mem_addr[7:0]];

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Exclusivity of grants/valids and a running count of fetch responses
    always @(negedge clk) begin
        if ((bus.if_gnt && bus.dm_gnt) || (bus.if_valid && bus.dm_valid)) overlap_cnt++;
        if (bus.if_valid) ifv_cnt++;
    end

    // Latency sweep instances: continuous fetches of 0x0040
    for (genvar g = 0; g < 2; g++) begin : sw
        localparam int L = (g == 0) ? 1 : 7;
        int gc [2];
        int vc [2];
        int ng;
        int nv;
        sisc_mem_arb_if #(.AW(16), .DW(32)) b ();
        sisc_mem_arb #(.AW(16), .DW(32), .LAT(L)) u_sw (
            .clk   (clk),
            .rst_f (rst_f),
            .bus   (b.slave)
        );
        assign b.if_req    = sw_req;
        assign b.if_addr   = 16'h0040;
        assign b.dm_req    = 1'b0;
        assign b.dm_we     = 1'b0;
        assign b.dm_addr   = 16'h0000;
        assign b.dm_wdata  = 32'h0;
        assign b.mem_rdata = {16'hC0DE, b.mem_addr};
        always @(negedge clk) begin
            if (b.if_gnt && ng < 2) begin
                gc[ng] = cyc;
                ng++;
            end
            if (b.if_valid && nv < 2) begin
                vc[nv] = cyc;
                nv++;
            end
        end
    end

    task automatic chk_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {9'd0, bus.if_gnt, bus.if_valid, bus.if_rdata, bus.dm_gnt, bus.dm_valid,
                bus.dm_rdata, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (bus.busy && k < 20) begin
            step();
            k++;
        end
        chk_val("idle_timeout", 128'(bus.busy), 128'd0);
    endtask

    initial begin
        cyc = 0; n_cmp = 0; n_err = 0; overlap_cnt = 0; ifv_cnt = 0; ngr = 0;
        rst_f = 1'b0; sw_req = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = 16'h0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 16'h0; bus.dm_wdata = 32'h0;
        repeat (3) step();
        chk_val("reset_outs", all_outs(), 128'd0);
        rst_f = 1'b1;

        // Contention: both requesters held high for four grants
        bus.if_req = 1'b1; bus.if_addr = 16'h0010;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'h0020;
        for (int k = 0; k < 60 && ngr < 4; k++) begin
            step();
            if (bus.dm_gnt) begin gord[ngr] = 1; gcyc[ngr] = k + 1; ngr++; end
            else if (bus.if_gnt) begin gord[ngr] = 0; gcyc[ngr] = k + 1; ngr++; end
        end
        chk_val("contend_ngrants", 128'(ngr), 128'd4);
        chk_val("contend_first_cyc", 128'(gcyc[0]), 128'd1);
        chk_val("contend_spacing", 128'(gcyc[1] - gcyc[0]), 128'd5);
        for (int k = 0; k < 4; k++) begin
`ifdef SISC_MEM_ARB_RR_EN
            chk_val($sformatf("rr_order%0d", k), 128'(gord[k]), (k % 2 == 0) ? 128'd1 : 128'd0);
`else
            chk_val($sformatf("prio_order%0d", k), 128'(gord[k]), 128'd1);
`endif
        end
        // DM withdraws: IF must be granted right after the DM response
        bus.dm_req = 1'b0;
        t_last = gcyc[3];
        saw_if = 0; t_if = 0;
        for (int k = 0; k < 20 && saw_if == 0; k++) begin
            step();
            if (bus.if_gnt) begin saw_if = 1; t_if = t_last + k + 1; end
            if (bus.dm_gnt) saw_if = 2;
        end
        chk_val("if_after_dm", 128'(saw_if), 128'd1);
        chk_val("if_after_dm_cyc", 128'(t_if - t_last), 128'd5);
        bus.if_req = 1'b0;
        wait_idle();

        // Single fetch of 0x0010, cycle-by-cycle
        bus.if_req = 1'b1; bus.if_addr = 16'h0010;
        step();
        chk_val("f_gnt", {bus.if_gnt, bus.mem_en, bus.mem_we, bus.dm_gnt}, 128'b1100);
        chk_val("f_mem_addr", 128'(bus.mem_addr), 128'h0010);
        bus.if_req = 1'b0;
        step();
        chk_val("f_c2", {bus.if_gnt, bus.mem_en, bus.if_valid}, 128'b000);
        step();
        chk_val("f_c3_valid", 128'(bus.if_valid), 128'd0);
        step();
        chk_val("f_c4_valid", {bus.if_valid, bus.busy}, 128'b11);
        chk_val("f_c4_rdata", 128'(bus.if_rdata), 128'hDEADBEEF);
        step();
        chk_val("f_c5", {bus.busy, bus.if_valid}, 128'b00);

        // Store 0x12345678 to 0x0020, then load it back
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 16'h0020; bus.dm_wdata = 32'h12345678;
        step();
        chk_val("st_gnt", {bus.dm_gnt, bus.if_gnt, bus.mem_en, bus.mem_we}, 128'b1011);
        chk_val("st_wdata", 128'(bus.mem_wdata), 128'h12345678);
        bus.dm_req = 1'b0; bus.dm_we = 1'b0;
        step();
        chk_val("st_valid", {bus.dm_valid, bus.mem_we, bus.mem_en}, 128'b100);
        step();
        chk_val("st_done", {bus.busy, bus.dm_valid}, 128'b00);
        bus.dm_req = 1'b1; bus.dm_addr = 16'h0020;
        step();
        chk_val("ld_gnt", {bus.dm_gnt, bus.mem_we}, 128'b10);
        bus.dm_req = 1'b0;
        repeat (3) step();
        chk_val("ld_valid", 128'(bus.dm_valid), 128'd1);
        chk_val("ld_rdata", 128'(bus.dm_rdata), 128'h12345678);
        step();

        // Reset during WAIT of a fetch aborts it
        bus.if_req = 1'b1; bus.if_addr = 16'h0010;
        step();
        bus.if_req = 1'b0;
        step();
        #2 rst_f = 1'b0;
        #1 chk_val("abort_outs", all_outs(), 128'd0);
        v0 = ifv_cnt;
        step();
        step();
        rst_f = 1'b1;
        repeat (6) step();
        chk_val("abort_no_valid", 128'(ifv_cnt - v0), 128'd0);
        bus.if_req = 1'b1;
        step();
        chk_val("post_rst_gnt", 128'(bus.if_gnt), 128'd1);
        bus.if_req = 1'b0;
        repeat (3) step();
        chk_val("post_rst_valid", {bus.if_valid, bus.if_rdata}, {1'b1, 32'hDEADBEEF});
        step();

        // Latency sweep: back-to-back fetches on LAT=1 and LAT=7
        sw_req = 1'b1;
        repeat (30) step();
        sw_req = 1'b0;
        repeat (12) step();
        chk_val("l1_ng", 128'(sw[0].ng + sw[0].nv), 128'd4);
        chk_val("l1_lat0", 128'(sw[0].vc[0] - sw[0].gc[0]), 128'd2);
        chk_val("l1_lat1", 128'(sw[0].vc[1] - sw[0].gc[1]), 128'd2);
        chk_val("l1_space", 128'(sw[0].gc[1] - sw[0].gc[0]), 128'd4);
        chk_val("l1_rdata", 128'(sw[0].b.if_rdata), 128'hC0DE0040);
        chk_val("l7_ng", 128'(sw[1].ng + sw[1].nv), 128'd4);
        chk_val("l7_lat0", 128'(sw[1].vc[0] - sw[1].gc[0]), 128'd8);
        chk_val("l7_lat1", 128'(sw[1].vc[1] - sw[1].gc[1]), 128'd8);
        chk_val("l7_space", 128'(sw[1].gc[1] - sw[1].gc[0]), 128'd10);
        chk_val("l7_rdata", 128'(sw[1].b.if_rdata), 128'hC0DE0040);

        chk_val("gnt_valid_exclusive", 128'(overlap_cnt), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
